// File: rtl/hwpe_stream_fence_ctrl_pkg.sv
// Shared types and constants for the stream fence sequencer.
// State encoding and default beat-count width.
package hwpe_stream_package;

  localparam int HWPE_STREAM_FENCE_CTRL_LEN_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } fence_ctrl_state_e;

endpackage

// File: rtl/hwpe_stream_fence_ctrl_cnt.sv
// Generic counter with sync clear, enable and optional saturation.
// Used for beat, stall and watchdog counts.
module hwpe_stream_fence_ctrl_cnt #(
  parameter int WIDTH = 16,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_d, cnt_q;

  // clear has priority; saturating instances stop at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !(SAT && (&cnt_q))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hwpe_stream_fence_ctrl.sv
// Transfer sequencer for an NB_STREAMS-wide stream fence.
// Optional watchdog: HWPE_STREAM_FENCE_CTRL_TIMEOUT_EN.
module hwpe_stream_fence_ctrl
  import hwpe_stream_package::*;
#(
  parameter int NB_STREAMS  = 2,
  parameter int LEN_WIDTH   = HWPE_STREAM_FENCE_CTRL_LEN_W,
  parameter int STALL_WIDTH = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   start_i,
  input  logic [LEN_WIDTH-1:0]   len_i,
  input  logic [NB_STREAMS-1:0]  push_valid_i,
  input  logic                   pop_valid_i,
  input  logic [NB_STREAMS-1:0]  pop_ready_i,
  output logic                   gate_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [LEN_WIDTH-1:0]   beat_cnt_o,
  output logic [STALL_WIDTH-1:0] stall_cnt_o,
  output logic                   err_o
);

  fence_ctrl_state_e state_d, state_q;
  logic [LEN_WIDTH-1:0] len_d, len_q;
  logic [LEN_WIDTH-1:0] last_idx;
  logic in_run, beat, last_beat, stall, start_acc, cnt_clr;
  logic timeout;

  assign in_run    = (state_q == RUN);
  assign beat      = in_run & pop_valid_i & (&pop_ready_i);
  assign stall     = in_run & (|push_valid_i) & ~(&push_valid_i);
  assign start_acc = (state_q == IDLE) & start_i & ~clear_i;
  assign cnt_clr   = clear_i | start_acc;
  assign last_idx  = len_q - {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  assign last_beat = beat & (beat_cnt_o == last_idx);

  hwpe_stream_fence_ctrl_cnt #(
    .WIDTH (LEN_WIDTH),
    .SAT   (1'b0)
  ) i_beat_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (cnt_clr),
    .en_i    (beat),
    .cnt_o   (beat_cnt_o)
  );

  hwpe_stream_fence_ctrl_cnt #(
    .WIDTH (STALL_WIDTH),
    .SAT   (1'b1)
  ) i_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (cnt_clr),
    .en_i    (stall),
    .cnt_o   (stall_cnt_o)
  );

`ifdef HWPE_STREAM_FENCE_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;

  // watchdog restarts on each beat and whenever RUN is not active
  hwpe_stream_fence_ctrl_cnt #(
    .WIDTH (WD_W),
    .SAT   (1'b1)
  ) i_wd_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i | beat | ~in_run),
    .en_i    (in_run & ~beat),
    .cnt_o   (wd_cnt)
  );

  assign timeout = in_run & ~beat &
                   (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
  assign err_o   = (state_q == ERROR);
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  // transfer length is captured only on an accepted start
  always_comb begin
    len_d = len_q;
    if (clear_i)        len_d = '0;
    else if (start_acc) len_d = len_i;
  end

  // next-state logic; soft clear overrides everything
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i)
          state_d = (len_i == '0) ? DONE : RUN;
      end
      RUN: begin
        if (last_beat)    state_d = DONE;
        else if (timeout) state_d = ERROR;
      end
      DONE: state_d = IDLE;
`ifdef HWPE_STREAM_FENCE_CTRL_TIMEOUT_EN
      ERROR: state_d = ERROR;
`endif
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  // state and latched length registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
    end
  end

  assign gate_o = in_run;
  assign busy_o = in_run;
  assign done_o = (state_q == DONE);

endmodule
